ipv4_arp_learn: RTL and testbench
=================================

# ipv4_arp_learn

Hardware ARP learner and the initiator side of the ARP table management port. It accepts parsed ARP sender (IPv4, MAC) pairs from the packet path and scans the table row by row over the rd_req/rd_ack handshake. It then issues one wr_req/wr_ack write that updates the matching row or fills the first empty row. The block sits in the output-port-lookup pcore on the Bus2IP clock domain, beside the software register path that drives the same table port.

## Interface
- IPV4_ARP_LUT_ROWS, 32, number of table rows scanned
- IPV4_ARP_LUT_ROW_BITS, 5, row address width
- MAC_WIDTH, 48, ethernet address width
- ACK_TIMEOUT, 15, maximum cycles to wait for any ack
- Bus2IP_Clk  in  1  single clock for the block
- Bus2IP_Resetn  in  1  asynchronous, active-low reset
- i_learn_valid  in  1  learn request valid
- o_learn_ready  out  1  high only in IDLE; a request is accepted when valid && ready
- i_learn_ipv4  in  32  ARP sender IPv4 address
- i_learn_eth  in  MAC_WIDTH  ARP sender ethernet address
- o_learn_done  out  1  one-cycle pulse at the end of each accepted request
- o_learn_status  out  3  result code, valid while done is high
- o_learn_wr_cnt  out  32  count of table writes acked
- o_learn_drop_cnt  out  32  count of requests that ended in drop, reject or timeout
- o_ipv4_arp_lut_rd_req  out  1  one-cycle read request pulse
- i_ipv4_arp_lut_rd_ack  in  1  read ack; rd data is valid in the ack cycle
- o_ipv4_arp_lut_rd_addr  out  ROW_BITS  row to read
- i_ipv4_arp_lut_rd_eth_addr  in  MAC_WIDTH  row ethernet address
- i_ipv4_arp_lut_rd_ipv4_addr  in  32  row IPv4 address
- o_ipv4_arp_lut_wr_req  out  1  one-cycle write request pulse
- i_ipv4_arp_lut_wr_ack  in  1  write ack
- o_ipv4_arp_lut_wr_addr  out  ROW_BITS  row to write
- o_ipv4_arp_lut_wr_eth_addr  out  64  {16'h0, MAC}
- o_ipv4_arp_lut_wr_ipv4_addr  out  32  IPv4 to write

## Operation
- **Reset values:** all outputs 0 except o_learn_ready=1. FSM goes to IDLE. Counters clear.
- **Status codes:**
  - 0 REFRESH: match found with same MAC, no write
  - 1 UPDATE: match found, new MAC written
  - 2 INSERT: written to empty row
  - 3 REPLACE: victim row written
  - 4 FULL_DROP: table full, nothing written
  - 5 REJECT: bad input
  - 6 TIMEOUT: ack not received
- **Empty row:** a row with eth==0.
- **Match:** a non-empty row with ipv4 equal to the captured address.
- **IDLE:** on accept, capture the ipv4/eth pair.
  - If ipv4==0, eth==0 or eth[40]==1 (multicast/broadcast), go to DONE with REJECT.
  - Otherwise go to RD_REQ with row=0, empty_found=0.
- **RD_REQ:** pulse rd_req with rd_addr=row, then go to RD_WAIT.
- **RD_WAIT:** on rd_ack:
  - Match: record the row and go to DECIDE.
  - Empty row and !empty_found: record the row, set empty_found.
  - Otherwise, if row==ROWS-1, go to DECIDE; else row+1 and RD_REQ.
- **DECIDE:**
  - Match with equal eth: DONE with REFRESH.
  - Match with different eth: write that row, status UPDATE.
  - No match, empty_found: write the first empty row, status INSERT.
  - No match, table full: see Configuration.
- **WR_REQ:** pulse wr_req, then go to WR_WAIT.
- **WR_WAIT:** on wr_ack, increment wr_cnt and go to DONE.
- **Ack timeout:** a wait counter resets on entering RD_WAIT or WR_WAIT. If it reaches ACK_TIMEOUT with no ack, go to DONE with TIMEOUT.
- **DONE:** pulse done, drive status, then return to IDLE.
  - drop_cnt increments on FULL_DROP, REJECT and TIMEOUT.
- **Counters:** saturate at 32'hFFFFFFFF.
- **Out-of-state acks:** an ack arriving outside RD_WAIT/WR_WAIT is ignored.
- **Software collision:** the table gives rd priority over wr. Software traffic on the shared port is arbitrated outside this block. A lost ack surfaces as TIMEOUT.
- **Reset mid-operation:** aborts immediately; no done pulse, req outputs go low at once.

## Timing
- Table ack arrives the cycle after req, so each row costs 2 cycles.
- Accept at cycle 0; first rd_req at cycle 1.
- Match at row n: DECIDE at cycle 2n+3.
- Full scan with miss: DECIDE at cycle 2*ROWS+1, wr_req at cycle 2*ROWS+2, ack at 2*ROWS+3, done at 2*ROWS+4.
  - For 32 rows that is 68 cycles.
- REJECT: done at cycle 1.
- ready is low from the accept cycle until the cycle after done.
- rd_req and wr_req are never high in the same cycle.

## Configuration
- **ARP_LEARN_REPLACE_EN defined:**
  - On full table with no match, write the row at a round-robin victim pointer; status REPLACE.
  - The pointer is ROW_BITS wide, resets to 0, increments after each acked replace and wraps ROWS-1 to 0.
- **ARP_LEARN_REPLACE_EN undefined:** full table gives FULL_DROP; no victim pointer logic is built.

## Structure
- Shared package/include file holds:
  - the status code constants (0–6)
  - the FSM state encodings (IDLE, RD_REQ, RD_WAIT, DECIDE, WR_REQ, WR_WAIT, DONE)
  - the multicast bit index (40)
- No sub-module: the FSM, scan counter, wait counter and statistics counters stay in one module.

## Test plan
- Empty table; learn 10.0.0.1 / 00:11:22:33:44:55 -> 32 reads, wr_addr=0, status INSERT at cycle 68, wr_cnt=1.
- Row 3 holds 10.0.0.1/MAC A; learn the same pair -> reads stop at row 3, no wr_req, status REFRESH at cycle 10.
- Same setup, learn a new MAC B -> write row 3 with {16'h0,B}, status UPDATE.
- Learn eth ff:ff:ff:ff:ff:ff, and separately ipv4 0 -> no rd_req, REJECT at cycle 1, drop_cnt increments by 2 in total.
- Full table, three distinct misses -> with the macro: REPLACE to rows 0, 1, 2. Without the macro: FULL_DROP ×3, drop_cnt=3.
- Hold rd_ack low -> TIMEOUT after 15 wait cycles. Assert reset mid-scan -> outputs return to reset values and no done pulse occurs.

Source files
------------

// File: rtl/ipv4_arp_learn_pkg.sv
// Shared definitions for the ARP learner: FSM states, result codes and helpers.
package ipv4_arp_learn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StDecide,
        StWrReq,
        StWrWait,
        StDone
    } state_t;

    localparam logic [2:0] StatusRefresh  = 3'd0;
    localparam logic [2:0] StatusUpdate   = 3'd1;
    localparam logic [2:0] StatusInsert   = 3'd2;
    localparam logic [2:0] StatusReplace  = 3'd3;
    localparam logic [2:0] StatusFullDrop = 3'd4;
    localparam logic [2:0] StatusReject   = 3'd5;
    localparam logic [2:0] StatusTimeout  = 3'd6;

    // Individual/group bit of the first MAC octet (set for multicast and broadcast).
    localparam int unsigned MulticastBit = 40;

    // Results that count as a dropped request.
    function automatic logic status_is_drop(input logic [2:0] status);
        return (status == StatusFullDrop) || (status == StatusReject) ||
               (status == StatusTimeout);
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/ipv4_arp_learn.sv
// ARP learner: scans the ARP table for a sender (IPv4, MAC) pair and refreshes,
// updates or inserts it with a single table write.
// Optional feature macro: ARP_LEARN_REPLACE_EN -- on a full table, overwrite a
// round-robin victim row instead of dropping the request.
module ipv4_arp_learn
    import ipv4_arp_learn_pkg::*;
#(
    parameter int unsigned IPV4_ARP_LUT_ROWS     = 32,
    parameter int unsigned IPV4_ARP_LUT_ROW_BITS = 5,
    parameter int unsigned MAC_WIDTH             = 48,
    parameter int unsigned ACK_TIMEOUT           = 15
) (
    input  logic                             Bus2IP_Clk,
    input  logic                             Bus2IP_Resetn,

    input  logic                             i_learn_valid,
    output logic                             o_learn_ready,
    input  logic [31:0]                      i_learn_ipv4,
    input  logic [MAC_WIDTH-1:0]             i_learn_eth,
    output logic                             o_learn_done,
    output logic [2:0]                       o_learn_status,
    output logic [31:0]                      o_learn_wr_cnt,
    output logic [31:0]                      o_learn_drop_cnt,

    output logic                             o_ipv4_arp_lut_rd_req,
    input  logic                             i_ipv4_arp_lut_rd_ack,
    output logic [IPV4_ARP_LUT_ROW_BITS-1:0] o_ipv4_arp_lut_rd_addr,
    input  logic [MAC_WIDTH-1:0]             i_ipv4_arp_lut_rd_eth_addr,
    input  logic [31:0]                      i_ipv4_arp_lut_rd_ipv4_addr,

    output logic                             o_ipv4_arp_lut_wr_req,
    input  logic                             i_ipv4_arp_lut_wr_ack,
    output logic [IPV4_ARP_LUT_ROW_BITS-1:0] o_ipv4_arp_lut_wr_addr,
    output logic [63:0]                      o_ipv4_arp_lut_wr_eth_addr,
    output logic [31:0]                      o_ipv4_arp_lut_wr_ipv4_addr
);

    localparam int unsigned RowW  = IPV4_ARP_LUT_ROW_BITS;
    localparam int unsigned WaitW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [RowW-1:0]  LastRow  = RowW'(IPV4_ARP_LUT_ROWS - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(ACK_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [RowW-1:0]      row_q, row_d;
    logic [31:0]          ipv4_q, ipv4_d;
    logic [MAC_WIDTH-1:0] eth_q, eth_d;
    logic                 empty_found_q, empty_found_d;
    logic [RowW-1:0]      empty_row_q, empty_row_d;
    logic                 match_found_q, match_found_d;
    logic                 match_same_q, match_same_d;
    logic [RowW-1:0]      match_row_q, match_row_d;
    logic [RowW-1:0]      wr_row_q, wr_row_d;
    logic [2:0]           status_q, status_d;
    logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [31:0]          wr_cnt_q, wr_cnt_d;
    logic [31:0]          drop_cnt_q, drop_cnt_d;
`ifdef ARP_LEARN_REPLACE_EN
    logic [RowW-1:0]      victim_q, victim_d;
`endif

    logic rd_row_empty;
    logic rd_row_match;

    assign rd_row_empty = (i_ipv4_arp_lut_rd_eth_addr == '0);
    assign rd_row_match = !rd_row_empty && (i_ipv4_arp_lut_rd_ipv4_addr == ipv4_q);

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q       <= StIdle;
            row_q         <= '0;
            ipv4_q        <= '0;
            eth_q         <= '0;
            empty_found_q <= 1'b0;
            empty_row_q   <= '0;
            match_found_q <= 1'b0;
            match_same_q  <= 1'b0;
            match_row_q   <= '0;
            wr_row_q      <= '0;
            status_q      <= StatusRefresh;
            wait_cnt_q    <= '0;
            wr_cnt_q      <= '0;
            drop_cnt_q    <= '0;
`ifdef ARP_LEARN_REPLACE_EN
            victim_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            ipv4_q        <= ipv4_d;
            eth_q         <= eth_d;
            empty_found_q <= empty_found_d;
            empty_row_q   <= empty_row_d;
            match_found_q <= match_found_d;
            match_same_q  <= match_same_d;
            match_row_q   <= match_row_d;
            wr_row_q      <= wr_row_d;
            status_q      <= status_d;
            wait_cnt_q    <= wait_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
`ifdef ARP_LEARN_REPLACE_EN
            victim_q      <= victim_d;
`endif
        end
    end

    // Next-state: capture, row-by-row scan, decision, single write, result.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        ipv4_d        = ipv4_q;
        eth_d         = eth_q;
        empty_found_d = empty_found_q;
        empty_row_d   = empty_row_q;
        match_found_d = match_found_q;
        match_same_d  = match_same_q;
        match_row_d   = match_row_q;
        wr_row_d      = wr_row_q;
        status_d      = status_q;
        wait_cnt_d    = wait_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        drop_cnt_d    = drop_cnt_q;
`ifdef ARP_LEARN_REPLACE_EN
        victim_d      = victim_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_learn_valid) begin
                    ipv4_d = i_learn_ipv4;
                    eth_d  = i_learn_eth;
                    if ((i_learn_ipv4 == '0) || (i_learn_eth == '0) ||
                        i_learn_eth[MulticastBit]) begin
                        status_d = StatusReject;
                        state_d  = StDone;
                    end else begin
                        row_d         = '0;
                        empty_found_d = 1'b0;
                        match_found_d = 1'b0;
                        state_d       = StRdReq;
                    end
                end
            end
            StRdReq: begin
                wait_cnt_d = '0;
                state_d    = StRdWait;
            end
            StRdWait: begin
                if (i_ipv4_arp_lut_rd_ack) begin
                    if (rd_row_match) begin
                        match_found_d = 1'b1;
                        match_row_d   = row_q;
                        match_same_d  = (i_ipv4_arp_lut_rd_eth_addr == eth_q);
                        state_d       = StDecide;
                    end else begin
                        if (rd_row_empty && !empty_found_q) begin
                            empty_found_d = 1'b1;
                            empty_row_d   = row_q;
                        end
                        if (row_q == LastRow) begin
                            state_d = StDecide;
                        end else begin
                            row_d   = row_q + RowW'(1);
                            state_d = StRdReq;
                        end
                    end
                end else if (wait_cnt_q == WaitLast) begin
                    status_d = StatusTimeout;
                    state_d  = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StDecide: begin
                if (match_found_q) begin
                    if (match_same_q) begin
                        status_d = StatusRefresh;
                        state_d  = StDone;
                    end else begin
                        wr_row_d = match_row_q;
                        status_d = StatusUpdate;
                        state_d  = StWrReq;
                    end
                end else if (empty_found_q) begin
                    wr_row_d = empty_row_q;
                    status_d = StatusInsert;
                    state_d  = StWrReq;
                end else begin
`ifdef ARP_LEARN_REPLACE_EN
                    wr_row_d = victim_q;
                    status_d = StatusReplace;
                    state_d  = StWrReq;
`else
                    status_d = StatusFullDrop;
                    state_d  = StDone;
`endif
                end
            end
            StWrReq: begin
                wait_cnt_d = '0;
                state_d    = StWrWait;
            end
            StWrWait: begin
                if (i_ipv4_arp_lut_wr_ack) begin
                    wr_cnt_d = sat_inc(wr_cnt_q);
`ifdef ARP_LEARN_REPLACE_EN
                    if (status_q == StatusReplace) begin
                        victim_d = (victim_q == LastRow) ? '0 : victim_q + RowW'(1);
                    end
`endif
                    state_d = StDone;
                end else if (wait_cnt_q == WaitLast) begin
                    status_d = StatusTimeout;
                    state_d  = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StDone: begin
                if (status_is_drop(status_q)) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from state so reset drops the request strobes at once.
    always_comb begin
        o_learn_ready               = (state_q == StIdle);
        o_learn_done                = (state_q == StDone);
        o_learn_status              = (state_q == StDone) ? status_q : 3'd0;
        o_learn_wr_cnt              = wr_cnt_q;
        o_learn_drop_cnt            = drop_cnt_q;
        o_ipv4_arp_lut_rd_req       = (state_q == StRdReq);
        o_ipv4_arp_lut_rd_addr      = row_q;
        o_ipv4_arp_lut_wr_req       = (state_q == StWrReq);
        o_ipv4_arp_lut_wr_addr      = wr_row_q;
        o_ipv4_arp_lut_wr_eth_addr  = 64'(eth_q);
        o_ipv4_arp_lut_wr_ipv4_addr = ipv4_q;
    end

endmodule

// File: tb/tb_ipv4_arp_learn.sv
// Self-checking bench for ipv4_arp_learn: directed vectors, randomized learns
// against a table-level reference model, ack timeout and mid-scan reset.
module tb_ipv4_arp_learn;

    localparam int ROWS = 32;

    logic        clk;
    logic        rst_n;
    logic        learn_valid;
    logic        learn_ready;
    logic [31:0] learn_ipv4;
    logic [47:0] learn_eth;
    logic        learn_done;
    logic [2:0]  learn_status;
    logic [31:0] wr_cnt;
    logic [31:0] drop_cnt;
    logic        rd_req;
    logic        rd_ack;
    logic [4:0]  rd_addr;
    logic [47:0] rd_eth;
    logic [31:0] rd_ip;
    logic        wr_req;
    logic        wr_ack;
    logic [4:0]  wr_addr;
    logic [63:0] wr_eth;
    logic [31:0] wr_ip;

    ipv4_arp_learn dut (
        .Bus2IP_Clk                  (clk),
        .Bus2IP_Resetn               (rst_n),
        .i_learn_valid               (learn_valid),
        .o_learn_ready               (learn_ready),
        .i_learn_ipv4                (learn_ipv4),
        .i_learn_eth                 (learn_eth),
        .o_learn_done                (learn_done),
        .o_learn_status              (learn_status),
        .o_learn_wr_cnt              (wr_cnt),
        .o_learn_drop_cnt            (drop_cnt),
        .o_ipv4_arp_lut_rd_req       (rd_req),
        .i_ipv4_arp_lut_rd_ack       (rd_ack),
        .o_ipv4_arp_lut_rd_addr      (rd_addr),
        .i_ipv4_arp_lut_rd_eth_addr  (rd_eth),
        .i_ipv4_arp_lut_rd_ipv4_addr (rd_ip),
        .o_ipv4_arp_lut_wr_req       (wr_req),
        .i_ipv4_arp_lut_wr_ack       (wr_ack),
        .o_ipv4_arp_lut_wr_addr      (wr_addr),
        .o_ipv4_arp_lut_wr_eth_addr  (wr_eth),
        .o_ipv4_arp_lut_wr_ipv4_addr (wr_ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table memory behind the port; the reference model reads the same contents.
    logic [31:0] tbl_ip  [ROWS];
    logic [47:0] tbl_eth [ROWS];
    logic        rd_ack_en;
    logic        wr_ack_en;

    int errors;
    int checks;
    int exp_wr_cnt;
    int exp_drop_cnt;
    int mvictim;

    // Results captured by do_learn.
    int          r_st, r_cyc, r_nrd, r_nwr, r_both, r_rdy0, r_rdy_done, r_rdy_after;
    int          r_waddr;
    logic [63:0] r_weth;
    logic [31:0] r_wip;
    logic [31:0] r_wr_cnt, r_drop_cnt;

    localparam logic [47:0] MacA  = 48'h0011_2233_4455;
    localparam logic [47:0] MacB  = 48'h02AA_BBCC_DDEE;
    localparam logic [47:0] MacC  = 48'h0000_0000_0077;
    localparam logic [47:0] MacD  = 48'h0200_1234_5678;
    localparam logic [47:0] MacMc = 48'h0100_0000_0001;
    localparam logic [47:0] MacBc = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] Ip1   = 32'h0A00_0001;

    // Table responder: acks a request one cycle after it is seen.
    initial begin
        logic       rd_pend, wr_pend;
        logic [4:0] rd_pa, wr_pa;
        logic [63:0] wr_pe;
        logic [31:0] wr_pi;
        rd_pend = 1'b0;
        wr_pend = 1'b0;
        rd_pa = '0; wr_pa = '0; wr_pe = '0; wr_pi = '0;
        rd_ack = 1'b0;
        wr_ack = 1'b0;
        rd_eth = '0;
        rd_ip  = '0;
        forever begin
            @(posedge clk);
            #1;
            rd_ack = rd_pend && rd_ack_en;
            if (rd_ack) begin
                rd_eth = tbl_eth[rd_pa];
                rd_ip  = tbl_ip[rd_pa];
            end
            wr_ack = wr_pend && wr_ack_en;
            if (wr_ack) begin
                tbl_eth[wr_pa] = wr_pe[47:0];
                tbl_ip[wr_pa]  = wr_pi;
            end
            rd_pend = rd_req;
            rd_pa   = rd_addr;
            wr_pend = wr_req;
            wr_pa   = wr_addr;
            wr_pe   = wr_eth;
            wr_pi   = wr_ip;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < ROWS; i++) begin
            tbl_ip[i]  = '0;
            tbl_eth[i] = '0;
        end
    endtask

    task automatic fill_table();
        for (int i = 0; i < ROWS; i++) begin
            tbl_ip[i]  = 32'hC0A8_0000 + 32'(i + 1);
            tbl_eth[i] = 48'h0200_0000_0000 + 48'(i + 1);
        end
    endtask

    // Reference model: what the learn should produce given the current table.
    function automatic void model(input logic [31:0] ip, input logic [47:0] eth,
                                  output int st, output int cyc, output int nrd,
                                  output int waddr);
        int m;
        int e;
        m = -1;
        e = -1;
        waddr = -1;
        if (ip == 0 || eth == 0 || eth[40]) begin
            st = 5; cyc = 1; nrd = 0;
            return;
        end
        for (int i = 0; i < ROWS; i++) begin
            if (tbl_eth[i] != 0 && tbl_ip[i] == ip) begin
                m = i;
                break;
            end
            if (tbl_eth[i] == 0 && e < 0) e = i;
        end
        if (m >= 0) begin
            nrd = m + 1;
            if (tbl_eth[m] == eth) begin
                st = 0; cyc = 2 * m + 4;
            end else begin
                st = 1; cyc = 2 * m + 6; waddr = m;
            end
        end else begin
            nrd = ROWS;
            if (e >= 0) begin
                st = 2; cyc = 2 * ROWS + 4; waddr = e;
            end else begin
`ifdef ARP_LEARN_REPLACE_EN
                st = 3; cyc = 2 * ROWS + 4; waddr = mvictim;
`else
                st = 4; cyc = 2 * ROWS + 2;
`endif
            end
        end
    endfunction

    // Drive one learn request and observe until done (bounded).
    task automatic do_learn(input logic [31:0] ip, input logic [47:0] eth);
        int cyc;
        bit got;
        @(posedge clk);
        #1;
        learn_valid = 1'b1;
        learn_ipv4  = ip;
        learn_eth   = eth;
        r_rdy0 = int'(learn_ready);
        r_st = -1; r_cyc = -1; r_nrd = 0; r_nwr = 0; r_both = 0; r_rdy_done = -1;
        r_waddr = -1; r_weth = '0; r_wip = '0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            learn_valid = 1'b0;
            if (rd_req) r_nrd++;
            if (rd_req && wr_req) r_both++;
            if (wr_req) begin
                r_nwr++;
                r_waddr = int'(wr_addr);
                r_weth  = wr_eth;
                r_wip   = wr_ip;
            end
            if (learn_done) begin
                got = 1'b1;
                r_st = int'(learn_status);
                r_cyc = cyc;
                r_rdy_done = int'(learn_ready);
            end
        end
        @(posedge clk);
        #1;
        r_rdy_after = int'(learn_ready);
        r_wr_cnt    = wr_cnt;
        r_drop_cnt  = drop_cnt;
    endtask

    task automatic learn_check(input string tag, input logic [31:0] ip, input logic [47:0] eth,
                               input int st, input int cyc, input int nrd, input int waddr);
        do_learn(ip, eth);
        if (waddr >= 0) exp_wr_cnt++;
        if (st == 4 || st == 5 || st == 6) exp_drop_cnt++;
        if (st == 3) mvictim = (mvictim + 1) % ROWS;
        check({tag, " status"}, 64'(r_st), 64'(st));
        check({tag, " done_cycle"}, 64'(r_cyc), 64'(cyc));
        check({tag, " rd_reqs"}, 64'(r_nrd), 64'(nrd));
        check({tag, " wr_reqs"}, 64'(r_nwr), 64'((waddr >= 0) ? 1 : 0));
        if (waddr >= 0) begin
            check({tag, " wr_addr"}, 64'(r_waddr), 64'(waddr));
            check({tag, " wr_eth"}, r_weth, {16'h0, eth});
            check({tag, " wr_ipv4"}, 64'(r_wip), 64'(ip));
        end
        check({tag, " ready_at_accept"}, 64'(r_rdy0), 64'd1);
        check({tag, " ready_in_done"}, 64'(r_rdy_done), 64'd0);
        check({tag, " ready_after_done"}, 64'(r_rdy_after), 64'd1);
        check({tag, " rd_wr_overlap"}, 64'(r_both), 64'd0);
        check({tag, " wr_cnt"}, 64'(r_wr_cnt), 64'(exp_wr_cnt));
        check({tag, " drop_cnt"}, 64'(r_drop_cnt), 64'(exp_drop_cnt));
    endtask

    typedef struct {
        int          setup;   // 0 keep, 1 empty, 2 row 3 = Ip1/MacA, 3 full
        logic [31:0] ip;
        logic [47:0] eth;
        int          st;
        int          cyc;
        int          nrd;
        int          waddr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int st, cyc, nrd, waddr;
        logic [31:0] ip;
        logic [47:0] eth;
        logic [47:0] eth_pool[4];
        bit saw_done;

        errors = 0; checks = 0;
        exp_wr_cnt = 0; exp_drop_cnt = 0; mvictim = 0;
        rd_ack_en = 1'b1; wr_ack_en = 1'b1;
        learn_valid = 1'b0; learn_ipv4 = '0; learn_eth = '0;
        eth_pool[0] = MacA; eth_pool[1] = MacB; eth_pool[2] = MacC; eth_pool[3] = MacD;
        clear_table();

        vecs[0] = '{1, Ip1, MacA, 2, 68, 32, 0};
        vecs[1] = '{2, Ip1, MacA, 0, 10, 4, -1};
        vecs[2] = '{2, Ip1, MacB, 1, 12, 4, 3};
        vecs[3] = '{1, 32'h0A00_0009, MacBc, 5, 1, 0, -1};
        vecs[4] = '{1, 32'h0, MacA, 5, 1, 0, -1};
`ifdef ARP_LEARN_REPLACE_EN
        vecs[5] = '{3, 32'h1400_0001, MacA, 3, 68, 32, 0};
        vecs[6] = '{0, 32'h1400_0002, MacB, 3, 68, 32, 1};
        vecs[7] = '{0, 32'h1400_0003, MacD, 3, 68, 32, 2};
`else
        vecs[5] = '{3, 32'h1400_0001, MacA, 4, 66, 32, -1};
        vecs[6] = '{0, 32'h1400_0002, MacB, 4, 66, 32, -1};
        vecs[7] = '{0, 32'h1400_0003, MacD, 4, 66, 32, -1};
`endif

        // Reset state.
        rst_n = 1'b0;
        #2;
        check("reset ready", 64'(learn_ready), 64'd1);
        check("reset done", 64'(learn_done), 64'd0);
        check("reset status", 64'(learn_status), 64'd0);
        check("reset rd_req", 64'(rd_req), 64'd0);
        check("reset wr_req", 64'(wr_req), 64'd0);
        check("reset wr_cnt", 64'(wr_cnt), 64'd0);
        check("reset drop_cnt", 64'(drop_cnt), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors.
        for (int v = 0; v < 8; v++) begin
            case (vecs[v].setup)
                1: clear_table();
                2: begin
                    clear_table();
                    tbl_ip[3]  = Ip1;
                    tbl_eth[3] = MacA;
                end
                3: fill_table();
                default: ;
            endcase
            learn_check($sformatf("vec%0d", v), vecs[v].ip, vecs[v].eth, vecs[v].st,
                        vecs[v].cyc, vecs[v].nrd, vecs[v].waddr);
        end

        // Randomized learns against the reference model.
        for (int round = 0; round < 2; round++) begin
            clear_table();
            for (int k = 0; k < 12; k++) begin
                int r;
                r = int'($urandom_range(0, ROWS - 1));
                tbl_ip[r]  = 32'h0A01_0001 + 32'($urandom_range(0, 5));
                tbl_eth[r] = eth_pool[$urandom_range(0, 3)];
            end
            for (int k = 0; k < 10; k++) begin
                ip  = ($urandom_range(0, 9) == 0) ? 32'h0 :
                      32'h0A01_0001 + 32'($urandom_range(0, 5));
                eth = ($urandom_range(0, 9) == 0) ? MacMc : eth_pool[$urandom_range(0, 3)];
                model(ip, eth, st, cyc, nrd, waddr);
                learn_check($sformatf("rnd%0d_%0d", round, k), ip, eth, st, cyc, nrd, waddr);
            end
        end

        // Read ack never arrives: 15 wait cycles then timeout.
        clear_table();
        rd_ack_en = 1'b0;
        learn_check("timeout", 32'h0A00_004D, MacA, 6, 17, 1, -1);
        rd_ack_en = 1'b1;

        // Reset in the middle of a scan.
        clear_table();
        @(posedge clk);
        #1;
        learn_valid = 1'b1;
        learn_ipv4  = Ip1;
        learn_eth   = MacA;
        @(posedge clk);
        #1;
        learn_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset ready", 64'(learn_ready), 64'd1);
        check("midreset rd_req", 64'(rd_req), 64'd0);
        check("midreset wr_req", 64'(wr_req), 64'd0);
        check("midreset done", 64'(learn_done), 64'd0);
        check("midreset wr_cnt", 64'(wr_cnt), 64'd0);
        check("midreset drop_cnt", 64'(drop_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (learn_done || rd_req || wr_req) saw_done = 1'b1;
        end
        check("midreset no_activity", 64'(saw_done), 64'd0);
        check("midreset ready_after", 64'(learn_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
